// File: rtl/dff_mux_register_if.sv
// rtl/dff_mux_register_if.sv - control, data and output bundle for the mux/dff shift register
interface dff_mux_register_if #(
  parameter int width = 9
);
  logic             load_enable;
  logic             load;
  logic [width-1:0] data_in;
  logic             left_shift_enable;
  logic             left_shift_value;
  logic             right_shift_enable;
  logic             right_shift_value;
  logic             jump_LSb;
  logic [width-1:0] data_out;

  modport master (
    output load_enable,
    output load,
    output data_in,
    output left_shift_enable,
    output left_shift_value,
    output right_shift_enable,
    output right_shift_value,
    output jump_LSb,
    input  data_out
  );

  modport slave (
    input  load_enable,
    input  load,
    input  data_in,
    input  left_shift_enable,
    input  left_shift_value,
    input  right_shift_enable,
    input  right_shift_value,
    input  jump_LSb,
    output data_out
  );
endinterface

// File: rtl/dff_mux_register.sv
// rtl/dff_mux_register.sv - loadable left/right shift register built from per-bit 4:1 mux + enabled dff slices
module mux_4_to_1 (
  input  logic [1:0] sel,
  input  logic       in_hold,
  input  logic       in_load,
  input  logic       in_right,
  input  logic       in_left,
  output logic       out
);
  always_comb begin
    out = in_hold;
    case (sel)
      2'b00: out = in_hold;
      2'b01: out = in_load;
      2'b10: out = in_right;
      2'b11: out = in_left;
      default: out = in_hold;
    endcase
  end
endmodule

module dff (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic d,
  output logic q
);
  // reset wins over enable so a cleared register ignores any pending request
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (enable) begin
      q <= d;
    end
  end
endmodule

module dff_mux_register #(
  parameter int width = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  dff_mux_register_if.slave    bus
);
  logic             eff_load;
  logic             shift_left;
  logic             shift_right;
  logic [1:0]       sel;
  logic             enable;
  logic [width-1:0] q;

  assign eff_load    = bus.load_enable | bus.load;
  assign shift_left  = bus.left_shift_enable;
  assign shift_right = bus.right_shift_enable;

  // load forces 01, left shift forces 11 over right (10), so priority falls out of the encoding
  assign sel[1] = ~eff_load & (shift_left | shift_right);
  assign sel[0] = eff_load | shift_left;
  assign enable = eff_load | shift_left | shift_right;

  genvar i;
  generate
    for (i = 0; i < width; i++) begin : g_slice
      logic right_src;
      logic left_src;
      logic d;

      if (i == width - 1) begin : g_msb
        assign right_src = bus.right_shift_value;
      end else begin : g_inner_r
        assign right_src = q[i+1];
      end

      // bit 1 optionally takes the inserted bit too, giving the two-position SRT-2 step
      if (i == 0) begin : g_lsb
        assign left_src = bus.left_shift_value;
      end else if (i == 1) begin : g_jump
        assign left_src = bus.jump_LSb ? bus.left_shift_value : q[0];
      end else begin : g_inner_l
        assign left_src = q[i-1];
      end

      mux_4_to_1 u_mux (
        .sel      (sel),
        .in_hold  (q[i]),
        .in_load  (bus.data_in[i]),
        .in_right (right_src),
        .in_left  (left_src),
        .out      (d)
      );

      dff u_dff (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .d      (d),
        .q      (q[i])
      );
    end
  endgenerate

  assign bus.data_out = q;
endmodule

// File: tb/tb_dff_mux_register.sv
// tb/tb_dff_mux_register.sv - directed and randomized checks of dff_mux_register against a behavioural model
module tb_dff_mux_register;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dff_mux_register_if #(.width(W)) bus ();

  dff_mux_register #(.width(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] model;

  task automatic drive(input logic rst, input logic le, input logic ld, input logic [W-1:0] d,
                       input logic ls, input logic lsv, input logic rs, input logic rsv,
                       input logic jmp);
    reset                  = rst;
    bus.load_enable        = le;
    bus.load               = ld;
    bus.data_in            = d;
    bus.left_shift_enable  = ls;
    bus.left_shift_value   = lsv;
    bus.right_shift_enable = rs;
    bus.right_shift_value  = rsv;
    bus.jump_LSb           = jmp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] exp);
    compared++;
    assert (bus.data_out === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, bus.data_out, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur);
    int v;
    int top;
    top = 1 << (W - 1);
    v = int'(cur);
    if (reset) return '0;
    if (bus.load_enable || bus.load) return bus.data_in;
    if (bus.left_shift_enable) begin
      v = ((v * 2) % (top * 2)) + int'(bus.left_shift_value);
      if (bus.jump_LSb) v = (v & ~2) + (bus.left_shift_value ? 2 : 0);
      return W'(v);
    end
    if (bus.right_shift_enable) return W'((v / 2) + (bus.right_shift_value ? top : 0));
    return cur;
  endfunction

  initial begin
    drive(0, 0, 0, '0, 0, 0, 0, 0, 0);
    #1;

    drive(0, 1, 0, 8'hFF, 0, 0, 0, 0, 0); step(); check("preload_ff", 8'hFF);
    drive(1, 0, 0, 8'h00, 0, 0, 0, 0, 0); step(); check("reset_from_ff", 8'h00);

    drive(0, 1, 0, 8'b10110010, 0, 0, 0, 0, 0); step(); check("load", 8'b10110010);
    drive(0, 0, 0, 8'hFF, 0, 1, 0, 1, 1); step(); check("hold", 8'b10110010);
    drive(0, 0, 0, 8'h00, 1, 0, 0, 1, 0); step(); check("lshift_0", 8'b01100100);
    drive(0, 0, 0, 8'h00, 1, 1, 0, 0, 0); step(); check("lshift_1", 8'b11001001);
    drive(0, 0, 0, 8'h00, 0, 0, 1, 1, 1); step(); check("rshift_1", 8'b11100100);
    drive(0, 0, 0, 8'h00, 0, 1, 1, 0, 1); step(); check("rshift_0", 8'b01110010);

    drive(0, 0, 1, 8'b10110010, 0, 0, 0, 0, 1); step(); check("load_alt", 8'b10110010);
    drive(0, 0, 0, 8'h00, 1, 1, 0, 0, 1); step(); check("lshift_jump", 8'b01100111);

    drive(0, 1, 0, 8'b00001111, 1, 1, 1, 1, 1); step(); check("load_wins", 8'b00001111);
    drive(0, 0, 0, 8'h00, 1, 0, 1, 1, 0); step(); check("left_wins", 8'b00011110);

    drive(1, 0, 0, 8'h00, 1, 1, 0, 0, 0); step(); check("reset_mid_shift", 8'h00);
    drive(0, 0, 0, 8'h00, 1, 1, 0, 0, 0); step(); check("resume_from_zero", 8'h01);

    drive(0, 1, 0, 8'hA5, 0, 0, 0, 0, 0); step(); check("load_a5", 8'hA5);
    drive(1, 1, 1, 8'hFF, 1, 1, 1, 1, 1);
    #3; check("reset_is_sync", 8'hA5);
    drive(1, 1, 0, 8'hFF, 0, 0, 0, 0, 0); step(); check("reset_beats_load", 8'h00);

    model = 8'h00;
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
            W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      model = ref_next(model);
      step();
      check($sformatf("random_%0d", n), model);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
